// File: rtl/simon_kexp_arb.sv
// simon_kexp_arb: round-robin front end that shares one SIMON key expander between two requesters.
// Defining SIMON_KEY_CACHE_EN adds a one-entry cache of the last successfully expanded key and mode.
module simon_kexp_arb #(
  parameter int TIMEOUT = 255
) (
  input  logic         ck,
  input  logic         nrst,
  input  logic         req0_valid,
  input  logic         req1_valid,
  input  logic [127:0] req0_key,
  input  logic [127:0] req1_key,
  input  logic         req0_mode,
  input  logic         req1_mode,
  output logic         req0_ready,
  output logic         req1_ready,
  output logic         req0_done,
  output logic         req1_done,
  output logic         err,
  output logic [127:0] kexp_key,
  output logic         kexp_mode,
  output logic         kexp_k_valid,
  input  logic         kexp_k_ready,
  input  logic         kexp_exp_valid,
  output logic         sched_valid,
  output logic         sched_owner
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t         state_q, state_d;
  logic           grant_q, grant_d;
  logic           ptr_q, ptr_d;
  logic [127:0]   key_q, key_d;
  logic           mode_q, mode_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           sv_q, sv_d;
  logic           owner_q, owner_d;
  logic           sel;
  logic           cache_hit;

  assign kexp_key  = key_q;
  assign kexp_mode = mode_q;

`ifdef SIMON_KEY_CACHE_EN
  logic [127:0] ckey_q, ckey_d;
  logic         cmode_q, cmode_d;
  logic         cvalid_q, cvalid_d;

  // Lookup uses the latched key, so a hit is resolved in ISSUE before anything is sent to the expander.
  assign cache_hit = cvalid_q && (ckey_q == key_q) && (cmode_q == mode_q);

  always_comb begin
    ckey_d   = ckey_q;
    cmode_d  = cmode_q;
    cvalid_d = cvalid_q;
    if (state_q == DONE) begin
      ckey_d   = key_q;
      cmode_d  = mode_q;
      cvalid_d = 1'b1;
    end
    if (err) begin
      cvalid_d = 1'b0;
    end
  end

  always_ff @(posedge ck) begin
    if (!nrst) begin
      ckey_q   <= '0;
      cmode_q  <= 1'b0;
      cvalid_q <= 1'b0;
    end else begin
      ckey_q   <= ckey_d;
      cmode_q  <= cmode_d;
      cvalid_q <= cvalid_d;
    end
  end
`else
  assign cache_hit = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    ptr_d        = ptr_q;
    key_d        = key_q;
    mode_d       = mode_q;
    cnt_d        = cnt_q;
    sv_d         = sv_q;
    owner_d      = owner_q;
    sel          = 1'b0;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    req0_done    = 1'b0;
    req1_done    = 1'b0;
    err          = 1'b0;
    kexp_k_valid = 1'b0;
    sched_valid  = sv_q;
    sched_owner  = owner_q;

    // Outputs stay quiet while reset is held, even if a requester is already waiting.
    if (nrst) begin
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (req0_valid || req1_valid) begin
            sel        = (req0_valid && req1_valid) ? ptr_q : req1_valid;
            grant_d    = sel;
            ptr_d      = ~sel;
            key_d      = sel ? req1_key : req0_key;
            mode_d     = sel ? req1_mode : req0_mode;
            req0_ready = ~sel;
            req1_ready = sel;
            state_d    = ISSUE;
          end
        end
        ISSUE: begin
          if (cache_hit) begin
            state_d = DONE;
          end else if (kexp_k_ready) begin
            kexp_k_valid = 1'b1;
            sv_d         = 1'b0;
            sched_valid  = 1'b0;
            cnt_d        = '0;
            state_d      = WAIT;
          end
        end
        WAIT: begin
          if (kexp_exp_valid) begin
            state_d = DONE;
          end else if (cnt_q == CW'(TIMEOUT)) begin
            err     = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        DONE: begin
          req0_done   = ~grant_q;
          req1_done   = grant_q;
          sv_d        = 1'b1;
          owner_d     = grant_q;
          sched_valid = 1'b1;
          sched_owner = grant_q;
          state_d     = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge ck) begin
    if (!nrst) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      ptr_q   <= 1'b0;
      key_q   <= '0;
      mode_q  <= 1'b0;
      cnt_q   <= '0;
      sv_q    <= 1'b0;
      owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      key_q   <= key_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      sv_q    <= sv_d;
      owner_q <= owner_d;
    end
  end

endmodule

// File: tb/tb_simon_kexp_arb.sv
// tb_simon_kexp_arb: directed self-checking bench for simon_kexp_arb (TIMEOUT=16).
// Build with or without SIMON_KEY_CACHE_EN; the final scenario expects the matching behaviour.
module tb_simon_kexp_arb;

  logic         ck;
  logic         nrst;
  logic         req0_valid, req1_valid;
  logic [127:0] req0_key, req1_key;
  logic         req0_mode, req1_mode;
  logic         req0_ready, req1_ready;
  logic         req0_done, req1_done;
  logic         err;
  logic [127:0] kexp_key;
  logic         kexp_mode;
  logic         kexp_k_valid;
  logic         kexp_k_ready;
  logic         kexp_exp_valid;
  logic         sched_valid;
  logic         sched_owner;

  int checks   = 0;
  int failures = 0;

  localparam logic [127:0] K1 = 128'h56AB09BBA4F930110042AA2AFF020180;
  localparam logic [127:0] KA = 128'h0F0E0D0C0B0A09080706050403020100;
  localparam logic [127:0] KB = 128'h19181110090801001111222233334444;
  localparam logic [127:0] K2 = 128'hDEADBEEF00112233445566778899AABB;
  localparam logic [127:0] K3 = 128'h0123456789ABCDEFFEDCBA9876543210;

  simon_kexp_arb #(.TIMEOUT(16)) dut (
    .ck(ck), .nrst(nrst),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_key(req0_key), .req1_key(req1_key),
    .req0_mode(req0_mode), .req1_mode(req1_mode),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_done(req0_done), .req1_done(req1_done),
    .err(err),
    .kexp_key(kexp_key), .kexp_mode(kexp_mode), .kexp_k_valid(kexp_k_valid),
    .kexp_k_ready(kexp_k_ready), .kexp_exp_valid(kexp_exp_valid),
    .sched_valid(sched_valid), .sched_owner(sched_owner)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  task automatic nxt;
    @(posedge ck);
    #1;
  endtask

  task automatic look;
    #1;
  endtask

  task automatic chk(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic chkk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready0"}, req0_ready, 1'b0);
    chk({tag, "_ready1"}, req1_ready, 1'b0);
    chk({tag, "_done0"}, req0_done, 1'b0);
    chk({tag, "_done1"}, req1_done, 1'b0);
    chk({tag, "_err"}, err, 1'b0);
    chk({tag, "_kvalid"}, kexp_k_valid, 1'b0);
    chk({tag, "_sched_valid"}, sched_valid, 1'b0);
    chk({tag, "_sched_owner"}, sched_owner, 1'b0);
    chkk({tag, "_kexp_key"}, kexp_key, 128'h0);
    chk({tag, "_kexp_mode"}, kexp_mode, 1'b0);
  endtask

  initial begin
    logic g;
    nrst = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b0;
    req0_key = '0; req1_key = '0; req0_mode = 1'b0; req1_mode = 1'b0;
    kexp_k_ready = 1'b0; kexp_exp_valid = 1'b0;

    // Reset held with a pending request: everything must stay at zero.
    nxt; nxt; look;
    chk_all_zero("rst");
    req0_valid = 1'b0;
    nrst = 1'b1;
    nxt;

    // req0 alone, mode 64/128, exp_valid five cycles after k_valid.
    req0_valid = 1'b1; req0_key = K1; req0_mode = 1'b0; kexp_k_ready = 1'b1;
    look;
    chk("t1_ready0_c0", req0_ready, 1'b1);
    chk("t1_ready1_c0", req1_ready, 1'b0);
    nxt; req0_valid = 1'b0; look;
    chk("t1_kvalid_c1", kexp_k_valid, 1'b1);
    chkk("t1_key_c1", kexp_key, K1);
    chk("t1_mode_c1", kexp_mode, 1'b0);
    for (int c = 2; c <= 6; c++) begin
      nxt; kexp_exp_valid = (c == 6); look;
      chk("t1_kvalid_low", kexp_k_valid, 1'b0);
      chk("t1_no_early_done", req0_done, 1'b0);
    end
    nxt; kexp_exp_valid = 1'b0; look;
    chk("t1_done0_c7", req0_done, 1'b1);
    chk("t1_done1_c7", req1_done, 1'b0);
    chk("t1_sched_valid_c7", sched_valid, 1'b1);
    chk("t1_owner_c7", sched_owner, 1'b0);
    nxt; look;
    chk("t1_done_pulse", req0_done, 1'b0);
    chk("t1_sched_hold", sched_valid, 1'b1);

    // Fresh reset, then both requesters held high for four grants.
    nrst = 1'b0; nxt; nrst = 1'b1; nxt;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_key = KA; req1_key = KB; req0_mode = 1'b0; req1_mode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      g = 1'(i % 2);
      look;
      chk("t2_ready0", req0_ready, ~g);
      chk("t2_ready1", req1_ready, g);
      nxt; look;
      chk("t2_kvalid", kexp_k_valid, 1'b1);
      chkk("t2_key", kexp_key, g ? KB : KA);
      chk("t2_ignored_outside_idle", req0_ready | req1_ready, 1'b0);
      nxt; kexp_exp_valid = 1'b1; look;
      chk("t2_no_done_in_wait", req0_done | req1_done, 1'b0);
      nxt; kexp_exp_valid = 1'b0; look;
      chk("t2_done0", req0_done, ~g);
      chk("t2_done1", req1_done, g);
      chk("t2_single_done", req0_done & req1_done, 1'b0);
      chk("t2_owner", sched_owner, g);
      chk("t2_no_grant_in_done", req0_ready | req1_ready, 1'b0);
      nxt;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // kexp_k_ready low for four ISSUE cycles.
    req0_valid = 1'b1; req0_key = K2; req0_mode = 1'b1; kexp_k_ready = 1'b0;
    look;
    chk("t3_ready0", req0_ready, 1'b1);
    nxt; req0_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      look;
      chk("t3_kvalid_held", kexp_k_valid, 1'b0);
      chkk("t3_key_stable", kexp_key, K2);
      chk("t3_sched_valid_kept", sched_valid, 1'b1);
      nxt;
    end
    kexp_k_ready = 1'b1; look;
    chk("t3_kvalid_on_ready", kexp_k_valid, 1'b1);
    chkk("t3_key_issue", kexp_key, K2);
    chk("t3_sched_valid_drop", sched_valid, 1'b0);
    nxt; kexp_exp_valid = 1'b1; look;
    chk("t3_kvalid_one_cycle", kexp_k_valid, 1'b0);
    chkk("t3_key_wait", kexp_key, K2);
    nxt; kexp_exp_valid = 1'b0; look;
    chk("t3_done0", req0_done, 1'b1);
    nxt;

    // No exp_valid: err sixteen cycles after entering WAIT.
    req1_valid = 1'b1; req1_key = K3; req1_mode = 1'b0; look;
    chk("t4_ready1", req1_ready, 1'b1);
    chk("t4_ready0", req0_ready, 1'b0);
    nxt; req1_valid = 1'b0; look;
    chk("t4_kvalid", kexp_k_valid, 1'b1);
    nxt;
    for (int c = 2; c <= 17; c++) begin
      look;
      chk("t4_no_early_err", err, 1'b0);
      chk("t4_no_done", req1_done, 1'b0);
      nxt;
    end
    look;
    chk("t4_err", err, 1'b1);
    chk("t4_no_done_on_err", req1_done, 1'b0);
    chk("t4_sched_valid", sched_valid, 1'b0);
    nxt; look;
    chk("t4_err_pulse", err, 1'b0);
    chk("t4_sched_valid_after", sched_valid, 1'b0);
    chk("t4_no_done_after", req1_done, 1'b0);

    // Reset in WAIT aborts silently; req1 is serviced afterwards.
    req0_valid = 1'b1; req0_key = K1; req0_mode = 1'b0; look;
    chk("t5_ready0", req0_ready, 1'b1);
    nxt; req0_valid = 1'b0; look;
    chk("t5_kvalid", kexp_k_valid, 1'b1);
    nxt; nxt;
    nrst = 1'b0; req1_valid = 1'b1; req1_key = K3; req1_mode = 1'b1;
    nxt; look;
    chk_all_zero("t5_rst");
    nrst = 1'b1; look;
    chk("t5_ready1", req1_ready, 1'b1);
    nxt; req1_valid = 1'b0; look;
    chk("t5_kvalid_r1", kexp_k_valid, 1'b1);
    chkk("t5_key_r1", kexp_key, K3);
    chk("t5_mode_r1", kexp_mode, 1'b1);
    nxt; kexp_exp_valid = 1'b1; look;
    nxt; kexp_exp_valid = 1'b0; look;
    chk("t5_done1", req1_done, 1'b1);
    chk("t5_done0", req0_done, 1'b0);
    chk("t5_owner", sched_owner, 1'b1);
    chk("t5_sched_valid", sched_valid, 1'b1);
    nxt; look;
    chk("t5_done_pulse", req1_done, 1'b0);

    // Same key and mode again on req1.
    req1_valid = 1'b1; look;
    chk("t6_ready1", req1_ready, 1'b1);
    nxt; req1_valid = 1'b0; look;
`ifdef SIMON_KEY_CACHE_EN
    chk("t6_hit_no_kvalid", kexp_k_valid, 1'b0);
    chk("t6_hit_sched_kept", sched_valid, 1'b1);
    nxt; look;
    chk("t6_hit_done1", req1_done, 1'b1);
    chk("t6_hit_owner", sched_owner, 1'b1);
    chk("t6_hit_sched_valid", sched_valid, 1'b1);
`else
    chk("t6_kvalid", kexp_k_valid, 1'b1);
    chk("t6_sched_drop", sched_valid, 1'b0);
    nxt; kexp_exp_valid = 1'b1; look;
    chk("t6_no_early_done", req1_done, 1'b0);
    nxt; kexp_exp_valid = 1'b0; look;
    chk("t6_done1", req1_done, 1'b1);
    chk("t6_owner", sched_owner, 1'b1);
`endif
    nxt;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
